// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| finishes via the 2-cycle SPECIAL path.
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             ready_o,
  output logic             stallreq_ex_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPECIAL = 2'd1,
    CALC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part_quot;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dvs_mag;
  logic             neg_q;
  logic             neg_r;

  // Operand decode on the request inputs (only meaningful in IDLE)
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic             div_zero;
  logic             overflow;
  logic             is_special;

  assign dvd_neg    = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg    = signed_i & divisor_i[WIDTH-1];
  assign dvd_mag_in = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag_in = dvs_neg ? -divisor_i  : divisor_i;
  assign div_zero   = (divisor_i == '0);
  assign overflow   = signed_i
                    & (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                    & (divisor_i == '1);

`ifdef DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out  = ~div_zero & (dvd_mag_in < dvs_mag_in);
  assign is_special = div_zero | overflow | early_out;
`else
  assign is_special = div_zero | overflow;
`endif

  // One restoring step: shift {r,q} left, trial-subtract at WIDTH+1 bits
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;

  assign shifted   = {part_rem, part_quot[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_mag};
  assign rem_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quot_step = {part_quot[WIDTH-2:0], ~trial[WIDTH]};

  logic [WIDTH-1:0] fixed_quot;
  logic [WIDTH-1:0] fixed_rem;

  assign fixed_quot = neg_q ? -part_quot : part_quot;
  assign fixed_rem  = neg_r ? -part_rem  : part_rem;

  assign stallreq_ex_o = start_i & ~ready_o & ~cancel_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SPECIAL holds for two cycles so its result lands on the same commit step as CALC
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = is_special ? SPECIAL : CALC;
      SPECIAL: if (count != '0) state_nxt = DONE;
      CALC:    if (count == LAST_COUNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cancel_i) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      part_quot   <= '0;
      part_rem    <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      ready_o     <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (!cancel_i) begin
        case (state)
          IDLE: begin
            if (start_i) begin
              count   <= '0;
              dvs_mag <= dvs_mag_in;
              neg_q   <= 1'b0;
              neg_r   <= 1'b0;
              if (div_zero) begin
                part_quot <= '1;
                part_rem  <= dividend_i;
              end else if (overflow) begin
                part_quot <= {1'b1, {(WIDTH-1){1'b0}}};
                part_rem  <= '0;
`ifdef DIV_EARLY_OUT_EN
              end else if (early_out) begin
                part_quot <= '0;
                part_rem  <= dividend_i;
`endif
              end else begin
                part_quot <= dvd_mag_in;
                part_rem  <= '0;
                neg_q     <= dvd_neg ^ dvs_neg;
                neg_r     <= dvd_neg;
              end
            end
          end
          SPECIAL: begin
            count <= count + 1'b1;
            if (count != '0) begin
              quotient_o  <= fixed_quot;
              remainder_o <= fixed_rem;
              ready_o     <= 1'b1;
            end
          end
          CALC: begin
            if (count == LAST_COUNT) begin
              quotient_o  <= fixed_quot;
              remainder_o <= fixed_rem;
              ready_o     <= 1'b1;
            end else begin
              part_quot <= quot_step;
              part_rem  <= rem_step;
              count     <= count + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
`default_nettype none

module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        cancel_i;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        ready_o;
  logic        stallreq_ex_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .cancel_i      (cancel_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .ready_o       (ready_o),
    .stallreq_ex_o (stallreq_ex_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called at a negedge; drives the request and measures edges until ready_o.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input int lat);
    int n;
    int stalls;
    logic got;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    n      = 0;
    stalls = 0;
    got    = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      if (stallreq_ex_o) stalls++;
      n++;
      @(posedge clk);
    end
    check_eq({tag, " ready"}, {31'd0, got}, 32'd1);
    check_eq({tag, " latency"}, n, lat);
    check_eq({tag, " stall_cycles"}, stalls, lat);
    check_eq({tag, " stall_in_done"}, {31'd0, stallreq_ex_o}, 32'd0);
    check_eq({tag, " quotient"}, quotient_o, exp_q);
    check_eq({tag, " remainder"}, remainder_o, exp_r);
  endtask

  task automatic finish_op(input string tag);
    start_i = 1'b0;
    @(negedge clk);
    check_eq({tag, " ready_one_cycle"}, {31'd0, ready_o}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst        = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    cancel_i   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset quotient", quotient_o, 32'd0);
    check_eq("reset remainder", remainder_o, 32'd0);
    check_eq("reset ready", {31'd0, ready_o}, 32'd0);
    check_eq("reset stall", {31'd0, stallreq_ex_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    finish_op("divu_100_7");
    run_div("div_m20_3", 1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 33);
    finish_op("div_m20_3");
    run_div("rem_20_m3", 1'b1, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 32'd2, 33);
    finish_op("rem_20_m3");
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    finish_op("div_7_m2");
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    finish_op("divu_max_1");
    run_div("div_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 33);
    finish_op("div_m1_m1");

    run_div("divzero_u", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 2);
    finish_op("divzero_u");
    run_div("divzero_s", 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 2);
    finish_op("divzero_s");
    run_div("divzero_neg", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2);
    finish_op("divzero_neg");
    run_div("ovf_s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2);
    finish_op("ovf_s");
    run_div("ovf_u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, EARLY_LAT);
    finish_op("ovf_u");
    run_div("small_5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, EARLY_LAT);
    finish_op("small_5_9");

    // Start held through DONE: the second request is taken one IDLE cycle later
    run_div("b2b_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("b2b_second", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34);
    finish_op("b2b_second");

    signed_i   = 1'b0;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    start_i    = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel_i = 1'b1;
    #1;
    check_eq("cancel stall_low", {31'd0, stallreq_ex_o}, 32'd0);
    @(negedge clk);
    cancel_i = 1'b0;
    start_i  = 1'b0;
    check_eq("cancel quotient_hold", quotient_o, 32'd100);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    check_eq("cancel no_ready", {31'd0, seen}, 32'd0);

    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    start_i    = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid quotient", quotient_o, 32'd0);
    check_eq("rst_mid ready", {31'd0, ready_o}, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_div("after_rst", 1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 33);
    finish_op("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
